capture_unit: RTL and testbench
===============================

CAPTURE_UNIT -- requirements
Module: capture_unit

Interface
REQ-001 SHALL have parameter ENTRIES, default 384, meaning sample depth of each RAMqueue channel.
REQ-002 SHALL have parameter LOG2, default 9, meaning width of waddr and trig_pos.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous and active-low.
REQ-005 SHALL have port wrt_smpl  input  1  one-cycle strobe from the decimator: a new sample is present on the channel data bus.
REQ-006 SHALL have port run  input  1  capture-enable bit (TrigCfg[4]) from cmd_cfg.
REQ-007 SHALL have port capture_done  input  1  capture-done bit (TrigCfg[5]) from cmd_cfg.
REQ-008 SHALL have port triggered  input  1  trigger-logic qualified trigger, level.
REQ-009 SHALL have port trig_pos  input  LOG2  number of post-trigger samples, from cmd_cfg.
REQ-010 SHALL have port we  output  1  write enable shared by the five RAMqueue instances.
REQ-011 SHALL have port waddr  output  LOG2  RAM write address; after capture, the oldest-sample pointer consumed by cmd_cfg.
REQ-012 SHALL have port set_capture_done  output  1  one-cycle pulse to cmd_cfg to set TrigCfg[5].
REQ-013 SHALL have port armed  output  1  pre-trigger region full; trigger logic may accept a trigger.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, WRT, DONE.
REQ-015 IDLE: SHALL move to WRT when run=1 and capture_done=0; the counters smpl_cnt and trig_cnt SHALL clear on entry to WRT.
REQ-016 IDLE: waddr SHALL hold its value, so a dump after a capture reads from the oldest sample.
REQ-017 WRT: on each cycle with wrt_smpl=1 and no done condition, we SHALL be 1 for that cycle and waddr SHALL advance by 1 on the following edge.
REQ-018 waddr SHALL wrap from ENTRIES-1 to 0; it SHALL never hold a value of ENTRIES or greater.
REQ-019 smpl_cnt (LOG2+1 bits) SHALL count writes in WRT and saturate at ENTRIES.
REQ-020 armed SHALL be registered and set on the edge after (smpl_cnt + trig_pos) >= ENTRIES, with the sum computed at LOG2+1 bits without overflow.
REQ-021 armed SHALL clear on leaving WRT.
REQ-022 trig_cnt (LOG2 bits) SHALL increment on each write made while triggered=1.
REQ-023 Done condition: in WRT, triggered=1 and trig_cnt == trig_pos.
REQ-024 On the done condition, regardless of wrt_smpl, the block SHALL: pulse set_capture_done for exactly 1 cycle, suppress we that cycle, and move to DONE.
REQ-025 Because the done check has priority over the write, trig_pos=0 SHALL end the capture on the first cycle triggered=1, with zero post-trigger writes.
REQ-026 trig_pos >= ENTRIES SHALL be accepted; armed then sets immediately and older post-trigger data may be overwritten.
REQ-027 DONE: we=0 and waddr SHALL be frozen; the FSM SHALL return to IDLE when capture_done=0 (cleared by host write).
REQ-028 Deassertion of run in WRT SHALL return to IDLE with no set_capture_done pulse; waddr SHALL be kept.
REQ-029 we SHALL be 0 in IDLE and DONE whatever wrt_smpl is.
REQ-030 we SHALL be a single-cycle output per wrt_smpl; back-to-back wrt_smpl strobes SHALL each produce a write.

Reset
REQ-031 On rst_n=0, the state SHALL go to IDLE immediately, without waiting for clk.
REQ-032 On rst_n=0, waddr, smpl_cnt and trig_cnt SHALL clear to 0; we, set_capture_done and armed SHALL clear to 0.
REQ-033 Reset mid-capture SHALL drop the capture with no set_capture_done pulse.
REQ-034 After reset release, the first transition SHALL occur on the first rising clk edge with run=1 and capture_done=0.

Verification
REQ-035 Wrap check: run=1, trig_pos=10, triggered=0, 400 wrt_smpl strobes -> waddr goes 0..383, then 0..15; armed goes high on the edge after the 374th write.
REQ-036 Trigger check: continue from REQ-035, raise triggered -> exactly 10 further writes, then one set_capture_done pulse; we=0 thereafter; waddr frozen at 26.
REQ-037 trig_pos=0: triggered=1 after armed -> set_capture_done on the same cycle as the trigger, no write, FSM in DONE.
REQ-038 Done/restart: hold capture_done=1 with run=1 -> FSM stays in DONE, no writes; clear capture_done -> IDLE, then WRT with counters cleared and waddr continuing from its frozen value.
REQ-039 Abort: assert rst_n=0 asynchronously mid-WRT -> all outputs 0 before the next clk edge; deassert run in WRT -> IDLE with no set_capture_done pulse.
REQ-040 Full loop: run the capture end-to-end with cmd_cfg; a channel dump SHALL return 384 bytes starting at waddr, in write order.

Source files
------------

// File: rtl/capture_if.sv
// Capture handshake bundle between cmd_cfg / trigger logic / decimator and
// the capture unit. The master side drives sample strobes and configuration,
// the slave side (capture_unit) returns RAM write control and status.
interface capture_if #(
    parameter int LOG2 = 9
);
    logic            wrt_smpl;
    logic            run;
    logic            capture_done;
    logic            triggered;
    logic [LOG2-1:0] trig_pos;
    logic            we;
    logic [LOG2-1:0] waddr;
    logic            set_capture_done;
    logic            armed;

    modport master (
        output wrt_smpl, run, capture_done, triggered, trig_pos,
        input  we, waddr, set_capture_done, armed
    );

    modport slave (
        input  wrt_smpl, run, capture_done, triggered, trig_pos,
        output we, waddr, set_capture_done, armed
    );
endinterface

// File: rtl/capture_unit.sv
// Capture controller for the RAMqueue channels: writes decimated samples into
// a circular buffer, arms once the pre-trigger region is full, and stops
// trig_pos samples after the trigger, leaving waddr on the oldest sample.
module capture_unit #(
    parameter int ENTRIES = 384,
    parameter int LOG2    = 9
) (
    input logic       clk,
    input logic       rst_n,
    capture_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WRT  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [LOG2:0]   DEPTH    = (LOG2+1)'(ENTRIES);
    localparam logic [LOG2-1:0] LAST     = LOG2'(ENTRIES - 1);
    localparam logic [LOG2:0]   CNT_ONE  = (LOG2+1)'(1);
    localparam logic [LOG2-1:0] ADDR_ONE = LOG2'(1);

    state_t          state;
    logic [LOG2-1:0] waddr_q;
    logic [LOG2:0]   smpl_cnt;
    logic [LOG2-1:0] trig_cnt;
    logic            armed_q;

    logic            done_hit;
    logic            write;
    logic [LOG2:0]   fill_sum;

    // Done check and write strobe; done has priority so trig_pos=0 writes nothing after the trigger.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch can be inferred.
        done_hit = 1'b0;
        write    = 1'b0;
        fill_sum = smpl_cnt + {1'b0, bus.trig_pos};
        if (state == WRT) begin
            done_hit = bus.triggered && (trig_cnt == bus.trig_pos);
            write    = bus.wrt_smpl && !done_hit;
        end
    end

    assign bus.we               = write;
    assign bus.set_capture_done = done_hit;
    assign bus.waddr            = waddr_q;
    assign bus.armed            = armed_q;

    // Capture FSM with write pointer, sample/trigger counters and armed flag.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            waddr_q  <= '0;
            smpl_cnt <= '0;
            trig_cnt <= '0;
            armed_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // waddr holds so a dump after capture starts at the oldest sample
                    if (bus.run && !bus.capture_done) begin
                        state    <= WRT;
                        smpl_cnt <= '0;
                        trig_cnt <= '0;
                    end
                end

                WRT: begin
                    if (write) begin
                        waddr_q <= (waddr_q == LAST) ? '0 : waddr_q + ADDR_ONE;
                        if (smpl_cnt != DEPTH) begin
                            smpl_cnt <= smpl_cnt + CNT_ONE;
                        end
                        if (bus.triggered) begin
                            trig_cnt <= trig_cnt + ADDR_ONE;
                        end
                    end

                    if (done_hit) begin
                        state   <= DONE;
                        armed_q <= 1'b0;
                    end else if (!bus.run) begin
                        // abort: no set_capture_done, pointer kept
                        state   <= IDLE;
                        armed_q <= 1'b0;
                    end else begin
                        armed_q <= (fill_sum >= DEPTH);
                    end
                end

                DONE: begin
                    // host clears capture_done after reading the dump
                    if (!bus.capture_done) begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_capture_unit.sv
// Directed bench for capture_unit: reset, wrap/arm, trigger with post-trigger
// count, buffer dump order, trig_pos=0, oversized trig_pos, run abort and
// asynchronous reset.
module tb_capture_unit;

    localparam int ENTRIES = 384;
    localparam int LOG2    = 9;

    logic clk;
    logic rst_n;
    int   check_cnt = 0;
    int   pass_cnt  = 0;
    logic [15:0] tb_data;
    logic [15:0] mem [0:ENTRIES-1];
    int   base;

    capture_if #(.LOG2(LOG2)) bus ();

    capture_unit #(.ENTRIES(ENTRIES), .LOG2(LOG2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Channel RAM model fed by the unit's write port.
    always @(posedge clk) begin
        if (bus.we) mem[bus.waddr] <= tb_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n            = 1'b0;
        bus.wrt_smpl     = 1'b0;
        bus.run          = 1'b0;
        bus.capture_done = 1'b0;
        bus.triggered    = 1'b0;
        bus.trig_pos     = '0;
        tb_data          = '0;

        // reset state, before any clock edge
        #2;
        check("rst_we", 32'(bus.we), 0);
        check("rst_waddr", 32'(bus.waddr), 0);
        check("rst_scd", 32'(bus.set_capture_done), 0);
        check("rst_armed", 32'(bus.armed), 0);

        @(negedge clk);
        rst_n        = 1'b1;
        bus.trig_pos = 9'd10;
        bus.run      = 1'b1;
        next_cycle();   // IDLE -> WRT

        // 400 back-to-back writes: wrap after 383, armed after the 374th write + 1 edge
        for (int i = 0; i < 400; i++) begin
            bus.wrt_smpl = 1'b1;
            tb_data      = 16'(i);
            @(negedge clk);
            check("wrap_we", 32'(bus.we), 1);
            check("wrap_waddr", 32'(bus.waddr), 32'(i % ENTRIES));
            check("wrap_armed", 32'(bus.armed), (i >= 375) ? 1 : 0);
            check("wrap_scd", 32'(bus.set_capture_done), 0);
            next_cycle();
        end

        bus.wrt_smpl = 1'b0;
        @(negedge clk);
        check("gap_we", 32'(bus.we), 0);
        check("gap_waddr", 32'(bus.waddr), 16);
        check("gap_armed", 32'(bus.armed), 1);
        next_cycle();

        // trigger: exactly 10 further writes, then the done pulse
        bus.triggered = 1'b1;
        for (int j = 0; j < 10; j++) begin
            bus.wrt_smpl = 1'b1;
            tb_data      = 16'(400 + j);
            @(negedge clk);
            check("post_we", 32'(bus.we), 1);
            check("post_scd", 32'(bus.set_capture_done), 0);
            check("post_waddr", 32'(bus.waddr), 32'(16 + j));
            next_cycle();
        end
        bus.wrt_smpl = 1'b1;
        @(negedge clk);
        check("done_scd", 32'(bus.set_capture_done), 1);
        check("done_we", 32'(bus.we), 0);
        check("done_waddr", 32'(bus.waddr), 26);
        next_cycle();   // -> DONE
        bus.capture_done = 1'b1;
        bus.triggered    = 1'b0;

        // held in DONE while capture_done=1, run=1, strobes present
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("hold_we", 32'(bus.we), 0);
            check("hold_scd", 32'(bus.set_capture_done), 0);
            check("hold_waddr", 32'(bus.waddr), 26);
            check("hold_armed", 32'(bus.armed), 0);
            next_cycle();
        end

        // dump from waddr: oldest sample first, in write order
        base = int'(bus.waddr);
        for (int k = 0; k < ENTRIES; k++) begin
            check("dump", 32'(mem[(base + k) % ENTRIES]), 32'(26 + k));
        end

        // restart with trig_pos=0
        bus.trig_pos     = 9'd0;
        bus.capture_done = 1'b0;
        @(negedge clk);
        check("rel_we", 32'(bus.we), 0);
        next_cycle();   // DONE -> IDLE
        @(negedge clk);
        check("idle_we", 32'(bus.we), 0);
        check("idle_waddr", 32'(bus.waddr), 26);
        next_cycle();   // IDLE -> WRT

        for (int k = 0; k < ENTRIES; k++) begin
            if (k == 0) begin
                @(negedge clk);
                check("rs_we", 32'(bus.we), 1);
                check("rs_waddr", 32'(bus.waddr), 26);
                check("rs_armed", 32'(bus.armed), 0);
            end
            next_cycle();
        end
        bus.wrt_smpl = 1'b0;
        @(negedge clk);
        check("tp0_armed_pre", 32'(bus.armed), 0);
        check("tp0_waddr", 32'(bus.waddr), 26);
        next_cycle();
        @(negedge clk);
        check("tp0_armed", 32'(bus.armed), 1);
        next_cycle();

        bus.triggered = 1'b1;
        bus.wrt_smpl  = 1'b1;
        @(negedge clk);
        check("tp0_scd", 32'(bus.set_capture_done), 1);
        check("tp0_we", 32'(bus.we), 0);
        next_cycle();   // -> DONE
        bus.capture_done = 1'b1;
        bus.triggered    = 1'b0;
        @(negedge clk);
        check("tp0_scd_once", 32'(bus.set_capture_done), 0);
        check("tp0_done_we", 32'(bus.we), 0);
        check("tp0_done_armed", 32'(bus.armed), 0);
        check("tp0_done_waddr", 32'(bus.waddr), 26);
        next_cycle();

        // trig_pos beyond ENTRIES: armed immediately
        bus.trig_pos     = 9'd400;
        bus.capture_done = 1'b0;
        bus.wrt_smpl     = 1'b0;
        next_cycle();   // DONE -> IDLE
        next_cycle();   // IDLE -> WRT
        @(negedge clk);
        check("big_armed_pre", 32'(bus.armed), 0);
        next_cycle();
        @(negedge clk);
        check("big_armed", 32'(bus.armed), 1);
        next_cycle();

        // run abort
        for (int k = 0; k < 3; k++) begin
            bus.wrt_smpl = 1'b1;
            @(negedge clk);
            check("ab_waddr", 32'(bus.waddr), 32'(26 + k));
            next_cycle();
        end
        bus.wrt_smpl = 1'b0;
        bus.run      = 1'b0;
        @(negedge clk);
        check("ab_scd", 32'(bus.set_capture_done), 0);
        check("ab_armed_pre", 32'(bus.armed), 1);
        next_cycle();   // WRT -> IDLE
        bus.wrt_smpl = 1'b1;
        @(negedge clk);
        check("ab_we", 32'(bus.we), 0);
        check("ab_armed", 32'(bus.armed), 0);
        check("ab_waddr", 32'(bus.waddr), 29);
        check("ab_scd_idle", 32'(bus.set_capture_done), 0);
        next_cycle();

        // asynchronous reset mid-WRT
        bus.run = 1'b1;
        next_cycle();   // IDLE -> WRT
        @(negedge clk);
        check("ar_we", 32'(bus.we), 1);
        check("ar_waddr", 32'(bus.waddr), 29);
        next_cycle();   // write at 29
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_rst_we", 32'(bus.we), 0);
        check("ar_rst_waddr", 32'(bus.waddr), 0);
        check("ar_rst_armed", 32'(bus.armed), 0);
        check("ar_rst_scd", 32'(bus.set_capture_done), 0);
        @(negedge clk);
        rst_n        = 1'b1;
        bus.run      = 1'b0;
        bus.trig_pos = 9'd10;
        next_cycle();
        @(negedge clk);
        check("ar_idle_we", 32'(bus.we), 0);
        next_cycle();
        bus.run = 1'b1;
        next_cycle();   // first edge with run=1 -> WRT
        @(negedge clk);
        check("ar_wrt_we", 32'(bus.we), 1);
        check("ar_wrt_waddr", 32'(bus.waddr), 0);
        next_cycle();

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
